fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the rvseed core. It replaces the fixed PC register, next-PC mux and combinational instruction-ROM path with three parts:
- a PC generator with redirect input;
- a valid/ready request/response port to instruction memory with multiple requests in flight;
- a prefetch queue that hands {pc, inst} pairs to decode under backpressure.

---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generator, pipelined imem request/response port
// with in-order in-flight tracking, and a prefetch queue feeding decode.
module fetch_unit #(
  parameter int unsigned    XLEN            = 32,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter int unsigned    FQ_DEPTH        = 4,
  parameter int unsigned    MAX_OUTSTANDING = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            busy
);

  localparam int unsigned QPW = $clog2(FQ_DEPTH);
  localparam int unsigned QCW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned OPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SW  = ((QCW > OCW) ? QCW : OCW) + 1;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] q_pc   [FQ_DEPTH];
  logic [31:0]     q_inst [FQ_DEPTH];
  logic [QPW-1:0]  q_rd, q_wr;
  logic [QCW-1:0]  q_count;
  logic [XLEN-1:0] fl_addr [MAX_OUTSTANDING];
  logic [OPW-1:0]  fl_rd, fl_wr;
  logic [OCW-1:0]  outstanding, drop_cnt;

  logic            req_fire, rsp_fire, rsp_drop, q_push, q_pop, out_ok, credit_ok;
  logic [OCW-1:0]  out_next, drop_next;
  logic [QCW-1:0]  q_count_next;

  // Request gating: never exceed the in-flight limit, and reserve a queue slot
  // for every outstanding request so a response always has somewhere to land.
  always_comb begin
    out_ok         = outstanding < OCW'(MAX_OUTSTANDING);
    credit_ok      = (SW'(outstanding) + SW'(q_count)) < SW'(FQ_DEPTH);
    imem_req_valid = !rst && !redirect_valid && out_ok && credit_ok;
    imem_req_addr  = pc_q;
    inst_valid     = (q_count != '0) && !redirect_valid;
    inst_data      = (q_count != '0) ? q_inst[q_rd] : '0;
    inst_pc        = (q_count != '0) ? q_pc[q_rd]   : '0;
    busy           = outstanding != '0;
  end

  // Responses with nothing outstanding are ignored; pending drops or a
  // same-cycle redirect discard the response instead of queueing it.
  always_comb begin
    req_fire  = imem_req_valid && imem_req_ready;
    rsp_fire  = imem_rsp_valid && (outstanding != '0);
    rsp_drop  = rsp_fire && (redirect_valid || (drop_cnt != '0));
    q_push    = rsp_fire && !rsp_drop;
    q_pop     = inst_valid && inst_ready;
    out_next  = outstanding + OCW'(req_fire) - OCW'(rsp_fire);
    drop_next = drop_cnt;
    if (redirect_valid) begin
      drop_next = out_next;
    end else if (rsp_fire && (drop_cnt != '0)) begin
      drop_next = drop_cnt - OCW'(1);
    end
    q_count_next = q_count + QCW'(q_push) - QCW'(q_pop);
    if (redirect_valid) begin
      q_count_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      q_rd        <= '0;
      q_wr        <= '0;
      q_count     <= '0;
      fl_rd       <= '0;
      fl_wr       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_next;
      drop_cnt    <= drop_next;
      q_count     <= q_count_next;
      if (redirect_valid) begin
        pc_q <= redirect_pc & ~XLEN'(3);
        q_rd <= '0;
        q_wr <= '0;
      end else begin
        if (req_fire) pc_q <= pc_q + XLEN'(4);
        if (q_push)   q_wr <= q_wr + QPW'(1);
        if (q_pop)    q_rd <= q_rd + QPW'(1);
      end
      if (req_fire) fl_wr <= (fl_wr == OPW'(MAX_OUTSTANDING - 1)) ? '0 : fl_wr + OPW'(1);
      if (rsp_fire) fl_rd <= (fl_rd == OPW'(MAX_OUTSTANDING - 1)) ? '0 : fl_rd + OPW'(1);
    end
  end

  // Payload storage; contents are only observed through valid pointers.
  always_ff @(posedge clk) begin
    if (req_fire) fl_addr[fl_wr] <= pc_q;
    if (q_push) begin
      q_pc[q_wr]   <= fl_addr[fl_rd];
      q_inst[q_wr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed per-cycle vector table with hand-driven
// responses, then sequences against a small in-order latency memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        busy;

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FQ_DEPTH(4), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rdy; logic rspv; logic [31:0] rspd; logic ir; logic redir; logic [31:0] rpc;
    logic e_rv; logic [31:0] e_addr; logic e_iv; logic [31:0] e_pc; logic [31:0] e_data; logic e_busy;
  } vec_t;

  typedef struct { logic [31:0] addr; int due; } mreq_t;

  int checks = 0;
  int failures = 0;

  mreq_t       mq[$];
  logic [31:0] issue_log[$];
  int          cyc, lat, issued_tot, responded_tot, delivered, first_hs, first_iv, cur_out;
  logic [31:0] exp_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fdat(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic clear_model();
    mq.delete();
    issue_log.delete();
    cyc = 0; issued_tot = 0; responded_tot = 0; delivered = 0;
    first_hs = -1; first_iv = -1; exp_pc = 32'h0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; inst_ready = 1'b0;
    #1;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_inst_data", inst_data, 0);
    check("rst_inst_pc", inst_pc, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    @(posedge clk); #1;
  endtask

  // One cycle against the memory model; sampling happens before the active edge.
  task automatic mem_cycle();
    @(negedge clk);
    cur_out = issued_tot - responded_tot;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = fdat(mq[0].addr);
      void'(mq.pop_front());
      responded_tot++;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{imem_req_addr, cyc + lat});
      issue_log.push_back(imem_req_addr);
      issued_tot++;
      if (first_hs < 0) first_hs = cyc;
    end
    if (inst_valid && inst_ready) begin
      check("seq_inst_pc", inst_pc, exp_pc);
      check("seq_inst_data", inst_data, fdat(exp_pc));
      exp_pc += 32'd4;
      delivered++;
      if (first_iv < 0) first_iv = cyc;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  vec_t vecs[20];

  initial begin
    int busy_bad, busy_low, max_out;
    rst = 1'b1;
    lat = 1;
    vecs[0]  = '{1, 0, 32'h0,          0, 0, 32'h0,    1, 32'h0,    0, 32'h0,    32'h0,          0};
    vecs[1]  = '{1, 1, 32'h1111_1111,  0, 0, 32'h0,    1, 32'h4,    0, 32'h0,    32'h0,          1};
    vecs[2]  = '{0, 0, 32'h0,          0, 0, 32'h0,    1, 32'h8,    1, 32'h0,    32'h1111_1111,  1};
    vecs[3]  = '{1, 1, 32'h2222_2222,  0, 0, 32'h0,    1, 32'h8,    1, 32'h0,    32'h1111_1111,  1};
    vecs[4]  = '{1, 0, 32'h0,          0, 0, 32'h0,    1, 32'hC,    1, 32'h0,    32'h1111_1111,  1};
    vecs[5]  = '{1, 0, 32'h0,          0, 0, 32'h0,    0, 32'h10,   1, 32'h0,    32'h1111_1111,  1};
    vecs[6]  = '{1, 1, 32'h3333_3333,  0, 0, 32'h0,    0, 32'h10,   1, 32'h0,    32'h1111_1111,  1};
    vecs[7]  = '{1, 0, 32'h0,          0, 0, 32'h0,    0, 32'h10,   1, 32'h0,    32'h1111_1111,  1};
    vecs[8]  = '{1, 1, 32'h4444_4444,  1, 0, 32'h0,    0, 32'h10,   1, 32'h0,    32'h1111_1111,  1};
    vecs[9]  = '{1, 0, 32'h0,          0, 0, 32'h0,    1, 32'h10,   1, 32'h4,    32'h2222_2222,  0};
    vecs[10] = '{1, 0, 32'h0,          1, 1, 32'h1002, 0, 32'h14,   0, 32'h0,    32'h0,          1};
    vecs[11] = '{1, 0, 32'h0,          1, 0, 32'h0,    1, 32'h1000, 0, 32'h0,    32'h0,          1};
    vecs[12] = '{1, 1, 32'h5555_5555,  1, 0, 32'h0,    0, 32'h1004, 0, 32'h0,    32'h0,          1};
    vecs[13] = '{0, 1, 32'h6666_6666,  1, 0, 32'h0,    1, 32'h1004, 0, 32'h0,    32'h0,          1};
    vecs[14] = '{0, 0, 32'h0,          1, 0, 32'h0,    1, 32'h1004, 1, 32'h1000, 32'h6666_6666,  0};
    vecs[15] = '{0, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,    1, 32'h1004, 0, 32'h0,    32'h0,          0};
    vecs[16] = '{1, 0, 32'h0,          0, 0, 32'h0,    1, 32'h1004, 0, 32'h0,    32'h0,          0};
    vecs[17] = '{1, 1, 32'h7777_7777,  0, 0, 32'h0,    1, 32'h1008, 0, 32'h0,    32'h0,          1};
    vecs[18] = '{1, 1, 32'h8888_8888,  1, 1, 32'h2000, 0, 32'h100C, 0, 32'h0,    32'h0,          1};
    vecs[19] = '{0, 0, 32'h0,          1, 0, 32'h0,    1, 32'h2000, 0, 32'h0,    32'h0,          0};

    reset_dut();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      imem_req_ready = vecs[i].rdy;
      imem_rsp_valid = vecs[i].rspv;
      imem_rsp_data  = vecs[i].rspd;
      inst_ready     = vecs[i].ir;
      redirect_valid = vecs[i].redir;
      redirect_pc    = vecs[i].rpc;
      #1;
      check($sformatf("v%0d_req_valid", i), imem_req_valid, vecs[i].e_rv);
      check($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].e_addr);
      check($sformatf("v%0d_inst_valid", i), inst_valid, vecs[i].e_iv);
      check($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      if (vecs[i].e_iv) begin
        check($sformatf("v%0d_inst_pc", i), inst_pc, vecs[i].e_pc);
        check($sformatf("v%0d_inst_data", i), inst_data, vecs[i].e_data);
      end
      @(posedge clk); #1;
    end

    // Streaming at one instruction per cycle with a 1-cycle memory.
    reset_dut();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 20; i++) mem_cycle();
    check("stream_first_latency", first_iv - first_hs, 2);
    check("stream_delivered", delivered, 18);

    // Backpressure: credit stops issue at queue depth, then drain and resume.
    reset_dut();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) mem_cycle();
    check("bp_issued", issued_tot, 4);
    check("bp_req_valid_held", imem_req_valid, 0);
    check("bp_queue_full_valid", inst_valid, 1);
    inst_ready = 1'b1;
    for (int i = 0; i < 12; i++) mem_cycle();
    check("bp_delivered_min", delivered >= 4, 1);
    check("bp_log_size", issue_log.size() > 4, 1);
    if (issue_log.size() > 4) check("bp_resume_addr", issue_log[4], 32'h10);

    // 3-cycle memory: never more than 2 outstanding, busy tracks outstanding.
    reset_dut();
    lat = 3; imem_req_ready = 1'b1; inst_ready = 1'b1;
    busy_bad = 0; busy_low = 0; max_out = 0;
    for (int i = 0; i < 30; i++) begin
      mem_cycle();
      if (cur_out > max_out) max_out = cur_out;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      cur_out = issued_tot - responded_tot;
      if (busy !== (cur_out != 0)) busy_bad++;
      if (!busy) busy_low++;
      #1;
      @(posedge clk); #1;
      lat = 3;
    end
    check("lat3_max_outstanding", max_out, 2);
    check("lat3_busy_mismatch", busy_bad, 0);
    check("lat3_busy_low", busy_low, 0);
    check("lat3_delivered_min", delivered >= 8, 1);

    // Reset mid-stream with a full queue, then restart at RESET_PC.
    reset_dut();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) mem_cycle();
    check("mid_queue_full", inst_valid, 1);
    reset_dut();
    lat = 1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) mem_cycle();
    check("mid_restart_log", issue_log.size() > 0, 1);
    if (issue_log.size() > 0) check("mid_restart_addr", issue_log[0], 32'h0);
    check("mid_restart_delivered", delivered, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
